// File: rtl/uart_pkg.sv
// uart_pkg: shared constants, state enums and frame helper for uart_link.
// Optional build macro: UART_PARITY_EN adds an even-parity bit to the frame.
package uart_pkg;

  localparam int unsigned CLKS_PER_BIT_DEFAULT = 434;
  localparam int unsigned CNT_W = 16;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

`ifdef UART_PARITY_EN
  localparam int unsigned FRAME_BITS = 11;
`else
  localparam int unsigned FRAME_BITS = 10;
`endif

  typedef enum logic [2:0] {
    S_LO,
    S_HI,
    S_ARMED,
    S_BUSY,
    S_DONE
  } tx_state_t;

  typedef enum logic [2:0] {
    R_IDLE,
    R_START,
    R_DATA,
    R_PARITY,
    R_STOP,
    R_WAIT
  } rx_state_t;

  // Line level for frame position idx: start, data LSB first, optional parity, stop.
  function automatic logic frame_bit(input logic [7:0] d, input logic [3:0] idx);
    logic b;
    if (idx == 4'd0) b = START_LEVEL;
    else if (idx <= 4'd8) b = d[3'(idx - 4'd1)];
`ifdef UART_PARITY_EN
    else if (idx == 4'd9) b = ^d;
`endif
    else b = IDLE_LEVEL;
    return b;
  endfunction

endpackage

// File: rtl/uart_link_if.sv
// uart_link_if: board-side pins of uart_link (keys, switches, serial lines, LEDs).
interface uart_link_if;
  logic [1:0] KEY;
  logic [3:0] SW;
  logic       tx;
  logic       rx;
  logic [7:0] LED;

  modport master (output KEY, output SW, output rx, input tx, input LED);
  modport slave  (input KEY, input SW, input rx, output tx, output LED);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver (even parity with UART_PARITY_EN); shows last good byte.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] led
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);

  rx_state_t        state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [2:0]       bit_idx, bit_nx;
  logic [7:0]       shreg, shreg_nx;
  logic [7:0]       led_nx;
  logic             rx_s1, rx_s2;
`ifdef UART_PARITY_EN
  logic             par_ok, par_ok_nx;
`endif

  // Two-flop synchronizer for the asynchronous serial input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1 <= IDLE_LEVEL;
      rx_s2 <= IDLE_LEVEL;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
    end
  end

  // Receiver state and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= R_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      led     <= '0;
`ifdef UART_PARITY_EN
      par_ok  <= 1'b0;
`endif
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      bit_idx <= bit_nx;
      shreg   <= shreg_nx;
      led     <= led_nx;
`ifdef UART_PARITY_EN
      par_ok  <= par_ok_nx;
`endif
    end
  end

  // Next-state: mid-start check, per-bit sampling, stop/parity validation.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    bit_nx   = bit_idx;
    shreg_nx = shreg;
    led_nx   = led;
`ifdef UART_PARITY_EN
    par_ok_nx = par_ok;
`endif
    case (state)
      R_IDLE: begin
        if (rx_s2 == START_LEVEL) begin
          state_nx = R_START;
          cnt_nx   = '0;
        end
      end
      R_START: begin
        if (cnt == HALF_CNT) begin
          cnt_nx = '0;
          bit_nx = '0;
          state_nx = (rx_s2 == IDLE_LEVEL) ? R_IDLE : R_DATA;
        end else cnt_nx = cnt + CNT_W'(1);
      end
      R_DATA: begin
        if (cnt == LAST_CNT) begin
          cnt_nx   = '0;
          shreg_nx = {rx_s2, shreg[7:1]};
          if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
            state_nx = R_PARITY;
`else
            state_nx = R_STOP;
`endif
          end else bit_nx = bit_idx + 3'd1;
        end else cnt_nx = cnt + CNT_W'(1);
      end
`ifdef UART_PARITY_EN
      R_PARITY: begin
        if (cnt == LAST_CNT) begin
          cnt_nx    = '0;
          par_ok_nx = ((^shreg) == rx_s2);
          state_nx  = R_STOP;
        end else cnt_nx = cnt + CNT_W'(1);
      end
`endif
      R_STOP: begin
        if (cnt == LAST_CNT) begin
          cnt_nx = '0;
          if (rx_s2 == IDLE_LEVEL) begin
            state_nx = R_IDLE;
`ifdef UART_PARITY_EN
            if (par_ok) led_nx = shreg;
`else
            led_nx = shreg;
`endif
          end else state_nx = R_WAIT;
        end else cnt_nx = cnt + CNT_W'(1);
      end
      R_WAIT: begin
        if (rx_s2 == IDLE_LEVEL) state_nx = R_IDLE;
      end
      default: state_nx = R_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_link.sv
// uart_link: key-driven nibble loader and UART transmitter plus receiver.
// Optional build macro: UART_PARITY_EN (even parity on transmit and receive).
module uart_link
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input logic        CLOCK_50,
  input logic        rst_n,
  uart_link_if.slave link
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       LAST_BIT = 4'(FRAME_BITS - 1);

  logic [1:0]       key_s1, key_s2, key_d;
  logic             load_ev_c, step_ev_c;
  tx_state_t        state, state_nx;
  logic [7:0]       data, data_nx;
  logic [3:0]       bit_idx, bit_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             tx_q, tx_nx;
  logic [7:0]       led;

  // Key synchronizer plus one delay stage for falling-edge detection.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      key_s1 <= 2'b11;
      key_s2 <= 2'b11;
      key_d  <= 2'b11;
    end else begin
      key_s1 <= link.KEY;
      key_s2 <= key_s1;
      key_d  <= key_s2;
    end
  end

  assign load_ev_c = key_d[1] & ~key_s2[1];
  assign step_ev_c = key_d[0] & ~key_s2[0];

  // Transmit FSM state and serializer registers.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_LO;
      data    <= '0;
      bit_idx <= '0;
      cnt     <= '0;
      tx_q    <= IDLE_LEVEL;
    end else begin
      state   <= state_nx;
      data    <= data_nx;
      bit_idx <= bit_nx;
      cnt     <= cnt_nx;
      tx_q    <= tx_nx;
    end
  end

  // Nibble loading, arming and bit-timed serialization.
  always_comb begin
    state_nx = state;
    data_nx  = data;
    bit_nx   = bit_idx;
    cnt_nx   = cnt;
    tx_nx    = IDLE_LEVEL;
    case (state)
      S_LO: begin
        if (load_ev_c) data_nx[3:0] = link.SW;
        if (step_ev_c) state_nx = S_HI;
      end
      S_HI: begin
        if (load_ev_c) data_nx[7:4] = link.SW;
        if (step_ev_c) state_nx = S_ARMED;
      end
      S_ARMED: begin
        if (step_ev_c) begin
          state_nx = S_BUSY;
          bit_nx   = '0;
          cnt_nx   = '0;
          tx_nx    = START_LEVEL;
        end
      end
      S_BUSY: begin
        tx_nx = tx_q;
        if (cnt == LAST_CNT) begin
          cnt_nx = '0;
          if (bit_idx == LAST_BIT) begin
            state_nx = S_DONE;
            tx_nx    = IDLE_LEVEL;
          end else begin
            bit_nx = bit_idx + 4'd1;
            tx_nx  = frame_bit(data, bit_idx + 4'd1);
          end
        end else cnt_nx = cnt + CNT_W'(1);
      end
      S_DONE: begin
        if (step_ev_c) state_nx = S_LO;
      end
      default: state_nx = S_LO;
    endcase
  end

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk   (CLOCK_50),
    .rst_n (rst_n),
    .rx    (link.rx),
    .led   (led)
  );

  assign link.tx  = tx_q;
  assign link.LED = led;

endmodule

// File: tb/tb_uart_link.sv
// tb_uart_link: directed checks of uart_link with tx looped back to rx.
module tb_uart_link;
  import uart_pkg::*;

  localparam int unsigned CPB = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic inject;
  logic rx_drv;
  int   checks = 0;
  int   failures = 0;

  uart_link_if link ();

  assign link.rx = inject ? rx_drv : link.tx;

  uart_link #(.CLKS_PER_BIT(CPB)) dut (
    .CLOCK_50 (clk),
    .rst_n    (rst_n),
    .link     (link.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic press(input int k);
    link.KEY[k] = 1'b0;
    repeat (4) @(negedge clk);
    link.KEY[k] = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Waits (bounded) for a start bit on tx, then samples every bit mid-period.
  task automatic capture_frame(output logic [FRAME_BITS-1:0] bits);
    bit seen = 1'b0;
    bits = '1;
    for (int i = 0; i < 4000 && !seen; i++) begin
      @(negedge clk);
      if (link.tx == 1'b0) seen = 1'b1;
    end
    check("tx_start_seen", 32'(seen), 32'd1);
    if (seen) begin
      repeat (CPB / 2) @(negedge clk);
      bits[0] = link.tx;
      for (int b = 1; b < int'(FRAME_BITS); b++) begin
        repeat (CPB) @(negedge clk);
        bits[b] = link.tx;
      end
    end
  endtask

  // Loads both nibbles, arms, and sends while capturing the frame on tx.
  task automatic send_byte(input logic [7:0] b, output logic [FRAME_BITS-1:0] bits);
    link.SW = b[3:0];
    press(1);
    press(0);
    link.SW = b[7:4];
    press(1);
    press(0);
    fork
      capture_frame(bits);
      press(0);
    join
    repeat (CPB) @(negedge clk);
  endtask

  // Drives a hand-built frame onto rx, with selectable stop level and parity error.
  task automatic drive_frame(input logic [7:0] b, input logic stop, input logic bad_par);
    rx_drv = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef UART_PARITY_EN
    rx_drv = (^b) ^ bad_par;
    repeat (CPB) @(negedge clk);
`endif
    rx_drv = stop;
    repeat (CPB) @(negedge clk);
    rx_drv = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    logic [FRAME_BITS-1:0] bits;
    int lows;
    rst_n    = 1'b0;
    inject   = 1'b0;
    rx_drv   = 1'b1;
    link.KEY = 2'b11;
    link.SW  = 4'h0;
    repeat (3) @(negedge clk);
    check("reset_tx", 32'(link.tx), 32'd1);
    check("reset_led", 32'(link.LED), 32'h00);
    check("reset_state", 32'(dut.state), 32'(S_LO));
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // First byte 0xE7.
    send_byte(8'hE7, bits);
    check("e7_start", 32'(bits[0]), 32'd0);
    check("e7_data", 32'(bits[8:1]), 32'hE7);
    check("e7_stop", 32'(bits[FRAME_BITS-1]), 32'd1);
`ifdef UART_PARITY_EN
    check("e7_parity", 32'(bits[9]), 32'd0);
`endif
    check("e7_led", 32'(link.LED), 32'hE7);
    check("e7_state_done", 32'(dut.state), 32'(S_DONE));

    // Return to S_LO and send 0x10.
    press(0);
    check("back_to_lo", 32'(dut.state), 32'(S_LO));
    send_byte(8'h10, bits);
    check("b10_data", 32'(bits[8:1]), 32'h10);
    check("b10_led", 32'(link.LED), 32'h10);

    // Key events during S_BUSY must not disturb the frame.
    press(0);
    link.SW = 4'h3;
    press(1);
    press(0);
    link.SW = 4'hC;
    press(1);
    press(0);
    link.SW = 4'hF;
    fork
      capture_frame(bits);
      begin
        press(0);
        repeat (20) @(negedge clk);
        press(1);
        press(0);
        press(1);
      end
    join
    repeat (CPB) @(negedge clk);
    check("busy_data", 32'(bits[8:1]), 32'hC3);
    check("busy_stop", 32'(bits[FRAME_BITS-1]), 32'd1);
    check("busy_led", 32'(link.LED), 32'hC3);
    check("busy_state_done", 32'(dut.state), 32'(S_DONE));
    lows = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (link.tx == 1'b0) lows++;
    end
    check("no_second_frame", 32'(lows), 32'd0);

    // Glitch on rx.
    inject = 1'b1;
    rx_drv = 1'b0;
    repeat (3) @(negedge clk);
    rx_drv = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("glitch_led", 32'(link.LED), 32'hC3);

    // Framing error, then a good frame to show re-arming.
    drive_frame(8'h3C, 1'b0, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    check("framing_led", 32'(link.LED), 32'hC3);
    drive_frame(8'h5A, 1'b1, 1'b0);
    check("rearm_led", 32'(link.LED), 32'h5A);
`ifdef UART_PARITY_EN
    drive_frame(8'h3C, 1'b1, 1'b1);
    check("parity_bad_led", 32'(link.LED), 32'h5A);
`endif
    rx_drv = 1'b1;
    inject = 1'b0;

    // Reset in the middle of a frame.
    press(0);
    link.SW = 4'h5;
    press(1);
    press(0);
    link.SW = 4'hA;
    press(1);
    press(0);
    press(0);
    repeat (4 * CPB) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_tx", 32'(link.tx), 32'd1);
    check("midreset_led", 32'(link.LED), 32'h00);
    check("midreset_state", 32'(dut.state), 32'(S_LO));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    send_byte(8'hA5, bits);
    check("a5_data", 32'(bits[8:1]), 32'hA5);
    check("a5_led", 32'(link.LED), 32'hA5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_link.md
# uart_link

Pushbutton-driven 8N1 UART transmitter plus receiver for the 50 MHz board top level. The transmitter assembles a byte from two 4-bit switch nibbles, stepped through by two keys, and sends it on `tx`. The receiver deserializes `rx` and shows the last good byte on the LEDs. The system loops `tx` back to `rx` externally.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per UART bit (115200 baud at 50 MHz); legal range 16..65535.
- `CLOCK_50` in 1: system clock; every flop is clocked on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `KEY` in 2: active-low pushbuttons. KEY[1] is LOAD, KEY[0] is STEP.
- `SW` in 4: nibble source.
- `tx` out 1: serial output, idle high.
- `rx` in 1: serial input, idle high, asynchronous to `CLOCK_50`.
- `LED` out 8: last correctly received byte.

## Operation
- KEY inputs pass through a 2-flop synchronizer. A press is a falling edge of the synchronized signal and produces a one-cycle event. Held levels produce nothing.
- Transmit FSM states: S_LO, S_HI, S_ARMED, S_BUSY, S_DONE. Reset state is S_LO.
- S_LO: a LOAD event latches SW into data[3:0]. A STEP event moves to S_HI.
- S_HI: a LOAD event latches SW into data[7:4]. A STEP event moves to S_ARMED.
- S_ARMED: a STEP event starts a frame and moves to S_BUSY. LOAD events are ignored.
- S_BUSY: the frame is sent, in order: start bit (0), data[0]..data[7] LSB first, stop bit (1). Each bit lasts exactly CLKS_PER_BIT cycles. When the stop bit ends, the FSM moves to S_DONE. All key events are ignored in S_BUSY.
- S_DONE: `tx` is held at 1. A STEP event returns to S_LO. The data register keeps its value until it is reloaded.
- LOAD and STEP in the same cycle: LOAD is applied first, then the state advances.
- Receiver: `rx` passes through a 2-flop synchronizer.
  - An idle-to-0 transition starts a frame. The line is re-sampled at CLKS_PER_BIT/2. If it is 1 there, this is a glitch and the receiver returns to idle.
  - Each data bit is then sampled every CLKS_PER_BIT cycles, LSB first.
  - The stop bit is sampled the same way. If it is 1, the byte is copied to `LED`. If it is 0, the byte is discarded (framing error), and the receiver waits for the line to read 1 before it re-arms.
- Reset values: `tx`=1, `LED`=0x00, data=0x00, transmit FSM in S_LO, receiver idle, all counters 0.
- Reset asserted mid-frame aborts the frame immediately and applies the reset values above.

## Timing
- From a STEP event in S_ARMED to `tx` falling: 1 cycle. The synchronizer and edge detection add 3 cycles after the pin changes.
- Frame length: 10×CLKS_PER_BIT cycles, or 11× with parity.
- `LED` updates 1 cycle after the stop-bit sample point. That is about 9.5 bit times plus 3 cycles after the start edge at `rx`.
- The receiver tolerates ±2% baud mismatch.

## Configuration
- `UART_PARITY_EN` defined:
  - An even-parity bit is inserted between data[7] and the stop bit.
  - The receiver checks it. On a mismatch the byte is discarded and `LED` is unchanged.
- `UART_PARITY_EN` undefined: plain 8N1, no parity logic.

## Structure
- Package `uart_pkg` holds:
  - the default CLKS_PER_BIT;
  - the transmit and receive state enums;
  - the IDLE_LEVEL and START_LEVEL constants.
- One sub-module, `uart_rx`, contains the receiver. The top holds the key synchronizers, the nibble/transmit FSM and the serializer.

## Test plan
Use CLKS_PER_BIT=16 with `tx` looped to `rx`.
- Nibble load and send: SW=7, LOAD, STEP; SW=14, LOAD, STEP; STEP.
  - `tx` emits 0xE7 LSB first over 160 cycles.
  - `LED`=0xE7 after the frame.
  - FSM is in S_DONE.
- Second byte after return: STEP (back to S_LO); SW=0, LOAD, STEP; SW=1, LOAD, STEP; STEP → `LED`=0x10.
- Key events ignored while busy: LOAD and STEP pulses during S_BUSY.
  - Frame bits are unchanged.
  - No second frame is sent.
  - `LED` shows the intended byte.
- Glitch and framing errors:
  - A 3-cycle low pulse on `rx` produces no `LED` change.
  - A frame with stop bit 0 leaves `LED` unchanged.
- Reset mid-frame: assert `rst_n`=0 at bit 4.
  - `tx` goes to 1 immediately and `LED`=0x00.
  - The FSM returns to S_LO.
  - A subsequent byte 0xA5 is received correctly.
- Parity (`UART_PARITY_EN` defined):
  - 0xE7 is sent with parity bit 0.
  - A frame with the parity bit forced wrong leaves `LED` unchanged.
